// File: rtl/mem_arbiter.sv
// Non-preemptive I/D arbiter for a four-bank memory; grant is registered (visible one cycle after req).
// Owner commands pass through combinationally; busy bank or mem_stall stalls the owner, non-owner commands always stall.
module mem_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic          i_rd,
    input  logic          i_wr,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_data_in,
    output logic          i_grant,
    output logic          i_stall,
    output logic [DW-1:0] i_data_out,
    output logic          i_data_valid,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_data_in,
    output logic          d_grant,
    output logic          d_stall,
    output logic [DW-1:0] d_data_out,
    output logic          d_data_valid,
    output logic          d_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data_in,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [3:0]    mem_busy,
    input  logic          mem_stall,
    input  logic [DW-1:0] mem_data_out,
    input  logic          mem_err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              last;        // 1 = D side was granted most recently
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_side;    // 1 = read issued by D side
    logic              own_i;
    logic              own_d;
    logic              own_rd;
    logic              own_wr;
    logic [AW-1:0]     own_addr;
    logic [DW-1:0]     own_data;
    logic              accept;
    logic              ret_vld;
    logic              ret_d;

    assign own_i = (state == GNT_I) && !rst;
    assign own_d = (state == GNT_D) && !rst;

    always_comb begin
        own_rd   = 1'b0;
        own_wr   = 1'b0;
        own_addr = '0;
        own_data = '0;
        if (own_i) begin
            own_rd   = i_rd;
            own_wr   = i_wr;
            own_addr = i_addr;
            own_data = i_data_in;
        end else if (own_d) begin
            own_rd   = d_rd;
            own_wr   = d_wr;
            own_addr = d_addr;
            own_data = d_data_in;
        end
    end

    // rd and wr together is an illegal command: never forwarded, never stalled
    assign accept      = (own_rd ^ own_wr) && !mem_busy[own_addr[2:1]] && !mem_stall && !rst;
    assign mem_addr    = own_addr;
    assign mem_data_in = own_data;
    assign mem_rd      = own_rd && accept;
    assign mem_wr      = own_wr && accept;

    assign i_grant = own_i;
    assign d_grant = own_d;
    assign i_stall = own_i ? ((i_rd ^ i_wr) && !accept) : (!rst && i_req && (i_rd || i_wr));
    assign d_stall = own_d ? ((d_rd ^ d_wr) && !accept) : (!rst && d_req && (d_rd || d_wr));

    assign ret_vld      = tag_vld[RD_LAT-1] && !rst;
    assign ret_d        = tag_side[RD_LAT-1];
    assign i_data_valid = ret_vld && !ret_d;
    assign d_data_valid = ret_vld && ret_d;
    assign i_data_out   = i_data_valid ? mem_data_out : '0;
    assign d_data_out   = d_data_valid ? mem_data_out : '0;

    // memory errors follow an outstanding read return first, else the current owner
    assign i_err = (own_i && i_rd && i_wr) || (mem_err && !rst && (ret_vld ? !ret_d : own_i));
    assign d_err = (own_d && d_rd && d_wr) || (mem_err && !rst && (ret_vld ?  ret_d : own_d));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_req && d_req) state_nxt = last ? GNT_I : GNT_D;
                else if (i_req)     state_nxt = GNT_I;
                else if (d_req)     state_nxt = GNT_D;
            end
            GNT_I:   if (!i_req) state_nxt = d_req ? GNT_D : IDLE;
            GNT_D:   if (!d_req) state_nxt = i_req ? GNT_I : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b0;
            tag_vld  <= '0;
            tag_side <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state && state_nxt != IDLE)
                last <= (state_nxt == GNT_D);
            tag_vld[0]  <= mem_rd;
            tag_side[0] <= own_d;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_vld[k]  <= tag_vld[k-1];
                tag_side[k] <= tag_side[k-1];
            end
        end
    end
endmodule
